// File: rtl/irda_sir_transmitter.sv
// IrDA SIR transmitter: serialises one async frame (start, data LSB-first, stop)
// with RZI encoding, where every 0 bit is a short high pulse at the start of its period.
module irda_sir_transmitter #(
  parameter int BIT_CYCLES   = 5208,
  parameter int PULSE_CYCLES = 977,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_transmitter,
  input  logic                 ena_trans,
  input  logic                 start_trans,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 ir_tx,
  output logic                 busy,
  output logic                 trans_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cyc_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;

  logic [CW-1:0]        cyc_nxt;
  logic [DATA_BITS-1:0] shift_nxt;
  logic                 wrap;
  logic                 in_pulse_nxt;

  assign cyc_nxt      = cyc_cnt + CW'(1);
  assign shift_nxt    = shift >> 1;
  assign wrap         = (cyc_cnt == CW'(BIT_CYCLES - 1));
  assign in_pulse_nxt = (cyc_nxt < CW'(PULSE_CYCLES));

  // ir_tx is registered, so each branch loads the value the *next* cycle needs:
  // that cycle's bit and counter position decide whether the pulse is on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      ir_tx      <= 1'b0;
      busy       <= 1'b0;
      trans_done <= 1'b0;
    end else if (rst_transmitter) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      ir_tx      <= 1'b0;
      busy       <= 1'b0;
      trans_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state, counters and shift register.
      case (state)
        IDLE: begin
          trans_done <= 1'b0;
          ir_tx      <= 1'b0;
          if (ena_trans && start_trans) begin
            state   <= START;
            shift   <= tx_data;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            ir_tx   <= 1'b1;
          end
        end

        START, DATA, STOP: begin
          if (!ena_trans) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            ir_tx   <= 1'b0;
          end else if (!wrap) begin
            cyc_cnt <= cyc_nxt;
            unique case (state)
              START:   ir_tx <= in_pulse_nxt;
              DATA:    ir_tx <= in_pulse_nxt && !shift[0];
              default: ir_tx <= 1'b0;
            endcase
          end else begin
            cyc_cnt <= '0;
            unique case (state)
              START: begin
                state   <= DATA;
                bit_cnt <= '0;
                ir_tx   <= !shift[0];
              end
              DATA: begin
                shift <= shift_nxt;
                if (bit_cnt == BW'(DATA_BITS - 1)) begin
                  state <= STOP;
                  ir_tx <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + BW'(1);
                  ir_tx   <= !shift_nxt[0];
                end
              end
              default: begin
                state      <= DONE;
                trans_done <= 1'b1;
                ir_tx      <= 1'b0;
              end
            endcase
          end
        end

        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          trans_done <= 1'b0;
          ir_tx      <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          trans_done <= 1'b0;
          ir_tx      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irda_sir_transmitter.sv
// Scoreboard bench for irda_sir_transmitter: stimulus queues expected pulses and
// done strobes (edge number, length); a negedge monitor measures and compares them.
module tb_irda_sir_transmitter;

  localparam int BC = 16;
  localparam int PC = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst_transmitter = 1'b0;
  logic       ena_trans = 1'b0;
  logic       start_trans = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ir_tx, busy, trans_done;

  irda_sir_transmitter #(.BIT_CYCLES(BC), .PULSE_CYCLES(PC), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .rst_transmitter(rst_transmitter),
    .ena_trans(ena_trans), .start_trans(start_trans), .tx_data(tx_data),
    .ir_tx(ir_tx), .busy(busy), .trans_done(trans_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int is_done;
    int edge_no;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  edge_cnt = 0;
  int  pulse_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  task automatic push_ev(input int is_done, input int edge_no, input int len);
    ev_t e;
    e.is_done = is_done;
    e.edge_no = edge_no;
    e.len     = len;
    exp_q.push_back(e);
  endtask

  // zmask bit k set = bit period k is a 0 (pulse); only periods starting before limit
  task automatic push_frame(input int e0, input logic [9:0] zmask, input int limit, input bit full);
    for (int k = 0; k < 10; k++)
      if (zmask[k] && (k * BC < limit)) push_ev(0, e0 + k * BC, PC);
    if (full) push_ev(1, e0 + 10 * BC, 0);
  endtask

  // Monitor: a pulse is reported by its first visible edge and its length in cycles.
  logic prev_ir = 1'b0;
  int   p_start = 0;
  int   p_len = 0;
  always @(negedge clk) begin
    ev_t e;
    if (ir_tx && !prev_ir) begin
      p_start = edge_cnt;
      p_len   = 1;
    end else if (ir_tx) begin
      p_len++;
    end else if (prev_ir) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", p_start, -1);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 0, e.is_done);
        check("pulse_start", p_start, e.edge_no);
        check("pulse_len", p_len, e.len);
      end
    end
    prev_ir = ir_tx;
    if (trans_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", edge_cnt, -1);
      end else begin
        e = exp_q.pop_front();
        check("done_kind", 1, e.is_done);
        check("done_edge", edge_cnt, e.edge_no);
      end
    end
  end

  // Returns 1 time unit after edge e; inputs set then are sampled at edge e+1.
  task automatic goto_edge(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [7:0] data, output int e0);
    tx_data     = data;
    ena_trans   = 1'b1;
    start_trans = 1'b1;
    @(posedge clk);
    #1;
    e0 = edge_cnt;
    start_trans = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  int e0, e1, n0;

  initial begin
    // Reset held with a start request pending
    ena_trans   = 1'b1;
    start_trans = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", {ir_tx, busy, trans_done}, 0);
    end
    @(posedge clk);
    #1;
    start_trans = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {ir_tx, busy, trans_done}, 0);
    goto_edge(edge_cnt + 2);

    // 0xA5 with tx_data change at T+40 and ignored start at T+50
    n0 = pulse_cnt;
    start_frame(8'hA5, e0);
    push_frame(e0, 10'h0B5, 1000, 1'b1);
    goto_edge(e0 + 39);
    tx_data = 8'h00;
    goto_edge(e0 + 49);
    start_trans = 1'b1;
    goto_edge(e0 + 50);
    start_trans = 1'b0;
    goto_edge(e0 + 160);
    check("busy_in_done", busy, 1);
    check("done_in_done", trans_done, 1);
    goto_edge(e0 + 161);
    check("busy_first_idle", busy, 0);
    check("done_first_idle", trans_done, 0);
    check("a5_pulse_count", pulse_cnt - n0, 5);

    // Back-to-back start on the first IDLE cycle
    start_frame(8'h5A, e1);
    check("b2b_accept_edge", e1, e0 + 162);
    push_frame(e1, 10'h14B, 1000, 1'b1);
    goto_edge(e1 + 161);

    // Extreme data values
    n0 = pulse_cnt;
    start_frame(8'hFF, e0);
    push_frame(e0, 10'h001, 1000, 1'b1);
    goto_edge(e0 + 161);
    check("ff_pulse_count", pulse_cnt - n0, 1);

    n0 = pulse_cnt;
    start_frame(8'h00, e0);
    push_frame(e0, 10'h1FF, 1000, 1'b1);
    goto_edge(e0 + 161);
    check("zero_pulse_count", pulse_cnt - n0, 9);

    // Abort by dropping ena_trans at T+70, restart at T+80
    start_frame(8'hA5, e0);
    push_frame(e0, 10'h0B5, 70, 1'b0);
    goto_edge(e0 + 69);
    ena_trans = 1'b0;
    goto_edge(e0 + 70);
    check("abort_busy", busy, 0);
    check("abort_ir", ir_tx, 0);
    goto_edge(e0 + 79);
    start_frame(8'hA5, e1);
    check("restart_edge", e1, e0 + 80);
    push_frame(e1, 10'h0B5, 1000, 1'b1);
    goto_edge(e1 + 161);

    // Controller clear inside the bit-2 pulse
    start_frame(8'hA5, e0);
    push_ev(0, e0, PC);
    push_ev(0, e0 + 32, 1);
    goto_edge(e0 + 32);
    rst_transmitter = 1'b1;
    goto_edge(e0 + 33);
    check("clear_ir", ir_tx, 0);
    check("clear_busy", busy, 0);
    rst_transmitter = 1'b0;
    goto_edge(e0 + 170);
    check("clear_stays_idle", busy, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) goto_edge(edge_cnt + 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
